// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand (ID/EX) stage.
//   DEF_DATA_W / DEF_REG_AW / DEF_STALL_CW : default operand, register-index and
//                                            stall-counter widths
//   SHAMT_W / FUNC_W                       : shift-amount and R-type func widths
//   alu_op_e                               : ALUOp encodings seen by ALU_Control
package alu_operand_stage_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_REG_AW   = 3;
    localparam int DEF_STALL_CW = 8;
    localparam int SHAMT_W      = 5;
    localparam int FUNC_W       = 6;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bus bundle around the ID/EX operand stage.
//   dec_*  : decoded instruction from ID (valid/ready handshake)
//   exm_*  : EX/MEM producer, used for forwarding and load-use detection
//   wb_*   : MEM/WB producer, used for forwarding
//   ex_*   : registered operands/control toward ALU_Control and ALU
// Modports:
//   master : the surrounding pipeline (drives decode/forward/ex_ready)
//   slave  : the operand stage itself
interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
);

    logic              dec_valid;
    logic              dec_ready;
    logic [REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0] dec_rt;
    logic [REG_AW-1:0] dec_rd;
    logic [DATA_W-1:0] dec_rs_data;
    logic [DATA_W-1:0] dec_rt_data;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_is_imm;
    logic [SHAMT_W-1:0] dec_shamt;
    logic [1:0]        dec_alu_op;
    logic [FUNC_W-1:0] dec_func;

    logic              exm_wen;
    logic              exm_is_load;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_result;

    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_ina;
    logic [DATA_W-1:0] ex_inb;
    logic [SHAMT_W-1:0] ex_shamt;
    logic [1:0]        ex_alu_op;
    logic [FUNC_W-1:0] ex_func;
    logic [REG_AW-1:0] ex_rd;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rd, dec_rs_data, dec_rt_data,
               dec_imm, dec_is_imm, dec_shamt, dec_alu_op, dec_func,
               exm_wen, exm_is_load, exm_rd, exm_result,
               wb_wen, wb_rd, wb_data, ex_ready,
        input  dec_ready, ex_valid, ex_ina, ex_inb, ex_shamt, ex_alu_op,
               ex_func, ex_rd
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rd, dec_rs_data, dec_rt_data,
               dec_imm, dec_is_imm, dec_shamt, dec_alu_op, dec_func,
               exm_wen, exm_is_load, exm_rd, exm_result,
               wb_wen, wb_rd, wb_data, ex_ready,
        output dec_ready, ex_valid, ex_ina, ex_inb, ex_shamt, ex_alu_op,
               ex_func, ex_rd
    );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Combinational operand forwarding mux for one source register.
//   idx        : source register index (r0 reads as zero)
//   reg_data   : value read from the register file
//   exm_*      : EX/MEM producer (ignored while it is a load, data not ready)
//   wb_*       : MEM/WB producer
//   operand    : resolved operand value
// The younger EX/MEM result wins over MEM/WB when both target idx.
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exm_wen,
    input  logic              exm_is_load,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = reg_data;
        if (idx == '0) begin
            operand = '0;
        end else if (exm_wen && !exm_is_load && (exm_rd == idx)) begin
            operand = exm_result;
        end else if (wb_wen && (wb_rd == idx)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding ALU_Control and ALU.
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   flush      : kill stage contents (branch redirect), dominated by rst
//   bus        : decode handshake, forwarding sources, registered ex_* outputs
//   stall_cnt  : number of load-use bubbles inserted, saturating at all-ones
// Captures forwarded operands one cycle after acceptance, holds them while the
// ALU back-end stalls (ex_ready low), and refuses decode while an EX/MEM load
// feeds one of the instruction's live sources.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int STALL_CW = DEF_STALL_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_operand_stage_if.slave  bus,
    output logic [STALL_CW-1:0] stall_cnt
);

    function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              hazard;
    logic              can_adv;
    logic              accept;
    logic              bubble;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] inb_sel;

    logic               vld_p1;
    logic [DATA_W-1:0]  ina_p1;
    logic [DATA_W-1:0]  inb_p1;
    logic [SHAMT_W-1:0] shamt_p1;
    logic [1:0]         alu_op_p1;
    logic [FUNC_W-1:0]  func_p1;
    logic [REG_AW-1:0]  rd_p1;
    logic [STALL_CW-1:0] stall_cnt_p1;

    alu_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx         (bus.dec_rs),
        .reg_data    (bus.dec_rs_data),
        .exm_wen     (bus.exm_wen),
        .exm_is_load (bus.exm_is_load),
        .exm_rd      (bus.exm_rd),
        .exm_result  (bus.exm_result),
        .wb_wen      (bus.wb_wen),
        .wb_rd       (bus.wb_rd),
        .wb_data     (bus.wb_data),
        .operand     (rs_fwd)
    );

    alu_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx         (bus.dec_rt),
        .reg_data    (bus.dec_rt_data),
        .exm_wen     (bus.exm_wen),
        .exm_is_load (bus.exm_is_load),
        .exm_rd      (bus.exm_rd),
        .exm_result  (bus.exm_result),
        .wb_wen      (bus.wb_wen),
        .wb_rd       (bus.wb_rd),
        .wb_data     (bus.wb_data),
        .operand     (rt_fwd)
    );

    // ---- p0: hazard detection and handshake (combinational) ----
    always_comb begin
        hazard = 1'b0;
        // rt only matters when inb actually comes from the register file
        if (bus.exm_wen && bus.exm_is_load && (bus.exm_rd != '0)) begin
            hazard = (bus.exm_rd == bus.dec_rs) ||
                     (!bus.dec_is_imm && (bus.exm_rd == bus.dec_rt));
        end
    end

    assign can_adv       = !vld_p1 || bus.ex_ready;
    assign bus.dec_ready = can_adv && !hazard;
    assign accept        = bus.dec_valid && bus.dec_ready && !flush;
    assign bubble        = bus.dec_valid && hazard && can_adv && !flush;
    assign inb_sel       = bus.dec_is_imm ? bus.dec_imm : rt_fwd;

    // ---- p1: output register toward ALU_Control / ALU ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            ina_p1       <= '0;
            inb_p1       <= '0;
            shamt_p1     <= '0;
            alu_op_p1    <= '0;
            func_p1      <= '0;
            rd_p1        <= '0;
            stall_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1    <= 1'b1;
                ina_p1    <= rs_fwd;
                inb_p1    <= inb_sel;
                shamt_p1  <= bus.dec_shamt;
                alu_op_p1 <= bus.dec_alu_op;
                func_p1   <= bus.dec_func;
                rd_p1     <= bus.dec_rd;
            end else if (can_adv) begin
                // Stage drained without a replacement; payload left stale
                vld_p1 <= 1'b0;
            end
            if (bubble) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
        end
    end

    assign bus.ex_valid  = vld_p1;
    assign bus.ex_ina    = ina_p1;
    assign bus.ex_inb    = inb_p1;
    assign bus.ex_shamt  = shamt_p1;
    assign bus.ex_alu_op = alu_op_p1;
    assign bus.ex_func   = func_p1;
    assign bus.ex_rd     = rd_p1;
    assign stall_cnt     = stall_cnt_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by random traffic,
// a transaction-level reference model feeding a queue, and an independent
// monitor that checks each instruction as the ALU side consumes it.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [SW-1:0] stall_cnt;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    alu_operand_stage #(.DATA_W(DW), .REG_AW(AW), .STALL_CW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] ina;
        logic [DW-1:0] inb;
        logic [4:0]    shamt;
        logic [1:0]    op;
        logic [5:0]    func;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mvalid = 1'b0;
    bit            nvalid = 1'b0;
    logic [SW-1:0] mcnt = '0;
    logic [SW-1:0] ncnt = '0;
    bit            exp_ready = 1'b0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value a source register holds from this instruction's point of view:
    // r0 is zero, the youngest non-load producer wins, else the regfile read.
    function automatic logic [DW-1:0] src_val(input logic [AW-1:0] idx, input logic [DW-1:0] regv);
        if (idx == 0) return '0;
        if (bus.exm_wen && !bus.exm_is_load && bus.exm_rd == idx) return bus.exm_result;
        if (bus.wb_wen && bus.wb_rd == idx) return bus.wb_data;
        return regv;
    endfunction

    // Decide what the stage does at the coming edge given current inputs.
    task automatic model_eval();
        bit   hz;
        bit   can;
        exp_t e;
        hz  = bus.exm_wen && bus.exm_is_load && (bus.exm_rd != 0) &&
              ((bus.exm_rd == bus.dec_rs) || (!bus.dec_is_imm && bus.exm_rd == bus.dec_rt));
        can = !mvalid || bus.ex_ready;
        exp_ready = can && !hz;
        nvalid = mvalid;
        ncnt   = mcnt;
        if (rst) begin
            sbq.delete();
            nvalid = 1'b0;
            ncnt   = '0;
        end else if (flush) begin
            if (mvalid && !bus.ex_ready && sbq.size() > 0) void'(sbq.pop_front());
            nvalid = 1'b0;
        end else begin
            if (bus.dec_valid && exp_ready) begin
                e.ina   = src_val(bus.dec_rs, bus.dec_rs_data);
                e.inb   = bus.dec_is_imm ? bus.dec_imm : src_val(bus.dec_rt, bus.dec_rt_data);
                e.shamt = bus.dec_shamt;
                e.op    = bus.dec_alu_op;
                e.func  = bus.dec_func;
                e.rd    = bus.dec_rd;
                sbq.push_back(e);
                nvalid = 1'b1;
            end else if (can) begin
                nvalid = 1'b0;
            end
            if (bus.dec_valid && hz && can) ncnt = (mcnt == 8'hFF) ? mcnt : mcnt + 8'd1;
        end
    endtask

    // Called at posedge+2 with inputs already set; returns at next posedge+2.
    task automatic cycle();
        #1 model_eval();
        @(posedge clk);
        #1;
        mvalid = nvalid;
        mcnt   = ncnt;
        #1;
    endtask

    task automatic set_idle();
        bus.dec_valid   = 1'b0;
        bus.dec_rs      = 3'd1;
        bus.dec_rt      = 3'd2;
        bus.dec_rd      = 3'd4;
        bus.dec_rs_data = 8'h11;
        bus.dec_rt_data = 8'h22;
        bus.dec_imm     = 8'h33;
        bus.dec_is_imm  = 1'b0;
        bus.dec_shamt   = 5'd0;
        bus.dec_alu_op  = ALUOP_ADD;
        bus.dec_func    = 6'd0;
        bus.exm_wen     = 1'b0;
        bus.exm_is_load = 1'b0;
        bus.exm_rd      = 3'd0;
        bus.exm_result  = 8'h00;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = 3'd0;
        bus.wb_data     = 8'h00;
        bus.ex_ready    = 1'b1;
        flush           = 1'b0;
    endtask

    // Monitor: checks state every cycle and pops one expected instruction
    // whenever the ALU side consumes the stage output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #7;
            if (mon_en) begin
                check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, mvalid});
                check("dec_ready", {31'd0, bus.dec_ready}, {31'd0, exp_ready});
                check("stall_cnt", 32'(stall_cnt), 32'(mcnt));
                if (bus.ex_valid && bus.ex_ready && !rst) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_empty: output consumed, expected none (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        check("ex_ina", 32'(bus.ex_ina), 32'(e.ina));
                        check("ex_inb", 32'(bus.ex_inb), 32'(e.inb));
                        check("ex_shamt", 32'(bus.ex_shamt), 32'(e.shamt));
                        check("ex_alu_op", 32'(bus.ex_alu_op), 32'(e.op));
                        check("ex_func", 32'(bus.ex_func), 32'(e.func));
                        check("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                    end
                end
            end
        end
    end

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #2;
        cycle();
        mon_en = 1'b1;
        cycle();
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ex_ina", 32'(bus.ex_ina), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        #1 check("rst_dec_ready", {31'd0, bus.dec_ready}, 32'd1);

        // plain R-type add, no forwarding
        bus.dec_valid = 1'b1; bus.dec_rs_data = 8'h0A; bus.dec_rt_data = 8'h14;
        bus.dec_alu_op = ALUOP_RTYPE; bus.dec_func = 6'b000000;
        cycle();
        check("nofwd_ina", 32'(bus.ex_ina), 32'h0A);
        check("nofwd_inb", 32'(bus.ex_inb), 32'h14);
        check("nofwd_alu_sum", 32'(8'(bus.ex_ina + bus.ex_inb)), 32'h1E);

        // forwarding priority
        set_idle(); bus.dec_valid = 1'b1; bus.dec_rs = 3'd2;
        bus.exm_wen = 1'b1; bus.exm_rd = 3'd2; bus.exm_result = 8'h55;
        bus.wb_wen = 1'b1; bus.wb_rd = 3'd2; bus.wb_data = 8'hAA;
        cycle();
        check("fwd_exm", 32'(bus.ex_ina), 32'h55);
        bus.exm_wen = 1'b0;
        cycle();
        check("fwd_wb", 32'(bus.ex_ina), 32'hAA);
        bus.dec_rs = 3'd0;
        cycle();
        check("fwd_r0", 32'(bus.ex_ina), 32'h00);

        // load-use hazard, then the same load with an immediate inb
        set_idle(); bus.dec_valid = 1'b1; bus.dec_rt = 3'd3;
        bus.exm_wen = 1'b1; bus.exm_is_load = 1'b1; bus.exm_rd = 3'd3;
        #1 check("lu_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
        cycle();
        check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        bus.dec_is_imm = 1'b1;
        #1 check("lu_imm_ready", {31'd0, bus.dec_ready}, 32'd1);
        cycle();
        check("lu_imm_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lu_imm_inb", 32'(bus.ex_inb), 32'h33);
        check("lu_imm_cnt", 32'(stall_cnt), 32'd1);

        // backpressure holds the registered instruction (ina = 11)
        set_idle(); bus.ex_ready = 1'b0; bus.dec_valid = 1'b1; bus.dec_rs_data = 8'h77;
        #1 check("bp_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
        cycle();
        check("bp_hold_ina1", 32'(bus.ex_ina), 32'h11);
        cycle();
        check("bp_hold_ina2", 32'(bus.ex_ina), 32'h11);
        check("bp_hold_valid", {31'd0, bus.ex_valid}, 32'd1);
        bus.ex_ready = 1'b1;
        cycle();
        check("bp_advance_ina", 32'(bus.ex_ina), 32'h77);

        // flush beats accept and bubble counting
        set_idle(); bus.dec_valid = 1'b1; flush = 1'b1;
        cycle();
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        bus.exm_wen = 1'b1; bus.exm_is_load = 1'b1; bus.exm_rd = 3'd1;
        cycle();
        check("flush_cnt", 32'(stall_cnt), 32'd1);

        // saturation of the bubble counter
        flush = 1'b0;
        for (int i = 0; i < 260; i++) cycle();
        check("sat_cnt", 32'(stall_cnt), 32'hFF);

        // reset during a hold discards the held instruction
        set_idle(); bus.dec_valid = 1'b1;
        cycle();
        bus.ex_ready = 1'b0; bus.dec_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_hold_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_hold_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.dec_valid   = ($urandom_range(0, 3) != 0);
            bus.dec_rs      = 3'($urandom_range(0, 7));
            bus.dec_rt      = 3'($urandom_range(0, 7));
            bus.dec_rd      = 3'($urandom_range(0, 7));
            bus.dec_rs_data = 8'($urandom);
            bus.dec_rt_data = 8'($urandom);
            bus.dec_imm     = 8'($urandom);
            bus.dec_is_imm  = ($urandom_range(0, 2) == 0);
            bus.dec_shamt   = 5'($urandom);
            bus.dec_alu_op  = 2'($urandom_range(0, 2));
            bus.dec_func    = 6'($urandom);
            bus.exm_wen     = ($urandom_range(0, 1) == 0);
            bus.exm_is_load = ($urandom_range(0, 3) == 0);
            bus.exm_rd      = 3'($urandom_range(0, 7));
            bus.exm_result  = 8'($urandom);
            bus.wb_wen      = ($urandom_range(0, 1) == 0);
            bus.wb_rd       = 3'($urandom_range(0, 7));
            bus.wb_data     = 8'($urandom);
            bus.ex_ready    = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 63) == 0);
            cycle();
        end

        // drain
        rst = 1'b0;
        set_idle();
        for (int i = 0; i < 4; i++) cycle();
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
